sample_reorder_buffer: RTL and testbench

- Per-board reorder stage directly upstream of the DRAM write address generator.
- Takes a channel-interleaved 16-bit sample stream (all channels for time t, then all channels for t+1).
- Transposes 16 consecutive time steps into one 256-bit word per channel, prefixed by a timestamp word, in a ping-pong pair of banks.
- Presents a full bank as a 125-word burst, read one word per request with 1-cycle latency; one instance per board, its ready bit forms one bit of the downstream 8-bit ready mask.

---
 rtl/sample_reorder_buffer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_sample_reorder_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_reorder_buffer.sv
// ---------------------------------------------------------------------------
// sample_reorder_buffer
//
// Per-board reorder stage in front of the DRAM write address generator.
// A channel-interleaved 16-bit sample stream arrives as all channels for time t,
// then all channels for t+1, and so on. SAMPLES consecutive time steps are
// transposed into one SAMPLES*16-bit word per channel. Each block goes into one
// of two ping-pong banks and is preceded by a timestamp word. A full bank is
// presented as an (NUM_CH+1)-word burst: word 0 is the timestamp and words
// 1..NUM_CH are the channels. The burst is read one word per request, and each
// word appears one cycle after its request is accepted.
//
// Optional build macro:
//   ORDER_CHECK_EN : checks in_ch_id against the expected channel. On a
//                    mismatch it raises seq_err and discards the block being
//                    written. When the macro is undefined, in_ch_id is ignored
//                    and seq_err is tied to 0.
//
// Ports:
//   clk             : clock
//   rst_n           : synchronous active-low reset
//   in_valid        : input sample valid
//   in_data         : 16-bit sample value
//   in_ch_id        : channel index of the sample (checked only with ORDER_CHECK_EN)
//   in_timestamp    : sampling time, captured with the first sample of a block
//   BRAM_ready      : a full bank is available, or a burst is in progress
//   BRAM_rd_request : read the next word of the ready bank
//   BRAM_rd_data    : read word, valid the cycle after the accepted request
//   overflow        : sticky, a block was dropped because no bank was free
//   seq_err         : sticky, channel order violation seen
// ---------------------------------------------------------------------------
module sample_reorder_buffer #(
  parameter int NUM_CH    = 124,
  parameter int SAMPLES   = 16,
  parameter int TS_W      = 48,
  parameter int READY_GAP = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [15:0]             in_data,
  input  logic [6:0]              in_ch_id,
  input  logic [TS_W-1:0]         in_timestamp,
  output logic                    BRAM_ready,
  input  logic                    BRAM_rd_request,
  output logic [SAMPLES*16-1:0]   BRAM_rd_data,
  output logic                    overflow,
  output logic                    seq_err
);

  localparam int WORD_W = SAMPLES * 16;
  localparam int T_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int PTR_W  = $clog2(NUM_CH + 1);
  localparam int GAP_W  = $clog2(READY_GAP + 2);

  localparam logic [6:0]       LAST_CH  = 7'(NUM_CH - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(SAMPLES - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(READY_GAP);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BURST,
    RD_GAP
  } rd_state_t;

  // Bank storage. The timestamp word is kept in its own register per bank so
  // that a block start can write the timestamp and the first sample lane in
  // the same cycle through a single memory write port.
  logic [WORD_W-1:0] mem [2][NUM_CH];
  logic [TS_W-1:0]   ts_q [2];
  bank_state_t       bank_st [2];

  // Write-side state
  logic [6:0]     wr_ch;
  logic [T_W-1:0] wr_t;
  logic           filling;
  logic           wr_bank;

  // Read-side state
  rd_state_t        rd_state, rd_next;
  logic             rd_bank;
  logic [PTR_W-1:0] rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             oldest;

  // Write-side decode
  logic           mismatch;
  logic           discard;
  logic           sample_ok;
  logic [6:0]     cur_ch;
  logic [T_W-1:0] cur_t;
  logic           block_start;
  logic           block_end;
  logic [1:0]     avail;
  logic           claim_ok;
  logic           claim_bank;
  logic           wr_active;
  logic           wr_target;

  // Read-side decode
  logic any_full;
  logic rd_sel;
  logic accept;
  logic take;
  logic burst_end;

`ifdef ORDER_CHECK_EN
  assign mismatch = in_valid && (in_ch_id != wr_ch);
`else
  logic unused_ch_id;
  assign unused_ch_id = ^in_ch_id;
  assign mismatch     = 1'b0;
`endif

  // A mismatching sample restarts the block at position (0,0). It is then
  // accepted only if it claims to be channel 0.
  always_comb begin
    cur_ch      = mismatch ? 7'd0 : wr_ch;
    cur_t       = mismatch ? '0 : wr_t;
    sample_ok   = in_valid && (!mismatch || (in_ch_id == 7'd0));
    discard     = mismatch && filling;
    block_start = sample_ok && (cur_ch == 7'd0) && (cur_t == '0);
    block_end   = sample_ok && (cur_ch == LAST_CH) && (cur_t == LAST_T);
    // A bank that is being discarded in this cycle counts as free again.
    avail[0]    = (bank_st[0] == BANK_EMPTY) || (discard && !wr_bank);
    avail[1]    = (bank_st[1] == BANK_EMPTY) || (discard && wr_bank);
    claim_ok    = block_start && (|avail);
    claim_bank  = !avail[0];
    wr_active   = block_start ? claim_ok : (sample_ok && filling);
    wr_target   = block_start ? claim_bank : wr_bank;
  end

  // The reader may only start on a FULL bank. The older FULL bank is
  // preferred, and the other bank is the fallback when the oldest is not FULL.
  always_comb begin
    any_full   = (bank_st[0] == BANK_FULL) || (bank_st[1] == BANK_FULL);
    if (rd_state == RD_IDLE) begin
      rd_sel = (bank_st[oldest] == BANK_FULL) ? oldest : !oldest;
    end else begin
      rd_sel = rd_bank;
    end
    BRAM_ready = ((rd_state == RD_IDLE) && any_full && (gap_cnt == '0)) ||
                 (rd_state == RD_BURST);
    accept     = BRAM_rd_request && BRAM_ready;
    take       = accept && (rd_state == RD_IDLE);
    burst_end  = accept && (rd_state == RD_BURST) && (rd_ptr == LAST_PTR);
  end

  // Write counters, block ownership and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ch    <= 7'd0;
      wr_t     <= '0;
      filling  <= 1'b0;
      wr_bank  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (sample_ok) begin
        if (cur_ch == LAST_CH) begin
          wr_ch <= 7'd0;
          wr_t  <= (cur_t == LAST_T) ? '0 : cur_t + 1'b1;
        end else begin
          wr_ch <= cur_ch + 7'd1;
          wr_t  <= cur_t;
        end
        if (block_start) begin
          filling <= claim_ok;
          if (claim_ok) begin
            wr_bank <= claim_bank;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (block_end) begin
          filling <= 1'b0;
        end
      end else if (mismatch) begin
        wr_ch   <= 7'd0;
        wr_t    <= '0;
        filling <= 1'b0;
      end
    end
  end

  // Bank storage writes: a lane write per sample, and a timestamp per claim.
  always_ff @(posedge clk) begin
    if (wr_active) begin
      mem[wr_target][cur_ch][16*cur_t +: 16] <= in_data;
    end
    if (claim_ok) begin
      ts_q[claim_bank] <= in_timestamp;
    end
  end

  // Bank lifecycle. The reader and the writer never own the same bank, so
  // the later assignments only resolve writer-side overlaps (discard, then
  // reclaim, then fill completion).
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst_n) begin
        bank_st[b] <= BANK_EMPTY;
      end else begin
        if (burst_end && (rd_bank == 1'(b))) begin
          bank_st[b] <= BANK_EMPTY;
        end else if (take && (rd_sel == 1'(b))) begin
          bank_st[b] <= BANK_READING;
        end
        if (discard && (wr_bank == 1'(b))) begin
          bank_st[b] <= BANK_EMPTY;
        end
        if (claim_ok && (claim_bank == 1'(b))) begin
          bank_st[b] <= BANK_FILLING;
        end
        if (block_end && wr_active && (wr_target == 1'(b))) begin
          bank_st[b] <= BANK_FULL;
        end
      end
    end
  end

  // Age tracking. A bank that becomes FULL is the oldest unless the other
  // bank is already FULL and stays FULL in this cycle.
  logic other_fb;
  assign other_fb = !wr_target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oldest <= 1'b0;
    end else if (block_end && wr_active &&
                 !((bank_st[other_fb] == BANK_FULL) && !(take && (rd_sel == other_fb)))) begin
      oldest <= wr_target;
    end else if (take) begin
      oldest <= !rd_sel;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  // Read FSM next state. GAP lasts until the gap counter has counted down.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:  if (take)      rd_next = RD_BURST;
      RD_BURST: if (burst_end) rd_next = RD_GAP;
      RD_GAP:   if (gap_cnt <= GAP_W'(1)) rd_next = RD_IDLE;
      default:  rd_next = RD_IDLE;
    endcase
  end

  // Read pointer, gap counter and the registered read port. rd_ptr is
  // always 0 in IDLE, so the first accepted request returns the timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank      <= 1'b0;
      rd_ptr       <= '0;
      gap_cnt      <= '0;
      BRAM_rd_data <= '0;
    end else begin
      if (take) begin
        rd_bank <= rd_sel;
      end
      if (accept) begin
        rd_ptr <= burst_end ? '0 : rd_ptr + 1'b1;
        if (rd_ptr == '0) begin
          BRAM_rd_data <= {{(WORD_W-TS_W){1'b0}}, ts_q[rd_sel]};
        end else begin
          BRAM_rd_data <= mem[rd_sel][rd_ptr - 1'b1];
        end
      end
      if (burst_end) begin
        gap_cnt <= GAP_LOAD;
      end else if ((rd_state == RD_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

`ifdef ORDER_CHECK_EN
  // Sticky channel-order violation flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
    end else if (mismatch) begin
      seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_sample_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_sample_reorder_buffer
//
// Directed self-checking bench for sample_reorder_buffer with its default
// parameters. Each sample is {t[3:0], ch[6:0], tag[4:0]}, where the tag
// identifies the block. The expected words are rebuilt from that pattern and
// from the block timestamp.
// ---------------------------------------------------------------------------
module tb_sample_reorder_buffer;

  localparam int NUM_CH  = 124;
  localparam int SAMPLES = 16;
  localparam int BLK     = NUM_CH * SAMPLES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  in_data;
  logic [6:0]   in_ch_id;
  logic [47:0]  in_timestamp;
  logic         BRAM_ready;
  logic         BRAM_rd_request;
  logic [255:0] BRAM_rd_data;
  logic         overflow;
  logic         seq_err;

  int checks   = 0;
  int failures = 0;

  int           sidx, w, bursts, blk, pos;
  logic         pend, got;
  logic [255:0] cap;

  sample_reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ch_id        (in_ch_id),
    .in_timestamp    (in_timestamp),
    .BRAM_ready      (BRAM_ready),
    .BRAM_rd_request (BRAM_rd_request),
    .BRAM_rd_data    (BRAM_rd_data),
    .overflow        (overflow),
    .seq_err         (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] sampleVal(int t, int ch, logic [4:0] tag);
    return {4'(t), 7'(ch), tag};
  endfunction

  function automatic logic [255:0] expWord(int idx, logic [4:0] tag, logic [47:0] ts);
    logic [255:0] v;
    v = '0;
    if (idx == 0) begin
      v[47:0] = ts;
    end else begin
      for (int t = 0; t < SAMPLES; t++) v[16*t +: 16] = sampleVal(t, idx - 1, tag);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return to idle after the clock edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [6:0] id,
                               input logic [47:0] ts, input logic req);
    in_valid        = v;
    in_data         = d;
    in_ch_id        = id;
    in_timestamp    = ts;
    BRAM_rd_request = req;
    @(posedge clk);
    #1;
    in_valid        = 1'b0;
    BRAM_rd_request = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 7'h0, 48'h0, 1'b0);
  endtask

  // Stream the first stop_at samples of a block. Sample bad_at carries a
  // wrong channel id.
  task automatic sendBlock(input logic [4:0] tag, input logic [47:0] ts,
                           input int stop_at, input int bad_at);
    for (int i = 0; i < stop_at; i++) begin
      applyStimulus(1'b1, sampleVal(i / NUM_CH, i % NUM_CH, tag),
                    (i == bad_at) ? 7'((i % NUM_CH) + 1) : 7'(i % NUM_CH), ts, 1'b0);
    end
  endtask

  task automatic waitReady(input int max_cycles, input string tag);
    logic seen;
    seen = BRAM_ready;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      idle(1);
      seen = BRAM_ready;
    end
    checkOutput(tag, {255'b0, seen}, 256'd1);
  endtask

  task automatic readBurst(input logic [4:0] tag, input logic [47:0] ts, input string name);
    waitReady(8, {name, "_ready"});
    for (int k = 0; k <= NUM_CH; k++) begin
      applyStimulus(1'b0, 16'h0, 7'h0, 48'h0, 1'b1);
      checkOutput($sformatf("%s_w%0d", name, k), BRAM_rd_data, expWord(k, tag, ts));
    end
    checkOutput({name, "_ready_drop"}, {255'b0, BRAM_ready}, 256'd0);
  endtask

  task automatic doReset();
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    BRAM_rd_request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid        = 1'b0;
    in_data         = '0;
    in_ch_id        = '0;
    in_timestamp    = '0;
    BRAM_rd_request = 1'b0;
    doReset();

    // Reset state
    checkOutput("rst_ready",    {255'b0, BRAM_ready}, 256'd0);
    checkOutput("rst_rd_data",  BRAM_rd_data,         256'd0);
    checkOutput("rst_overflow", {255'b0, overflow},   256'd0);
    checkOutput("rst_seq_err",  {255'b0, seq_err},    256'd0);

    // Single block, then a 126-request readout
    sendBlock(5'd0, 48'h123456789ABC, BLK / 2, -1);
    checkOutput("fill_mid_ready", {255'b0, BRAM_ready}, 256'd0);
    sendBlock(5'd0, 48'h123456789ABC, 0, -1);
    for (int i = BLK / 2; i < BLK; i++) begin
      applyStimulus(1'b1, sampleVal(i / NUM_CH, i % NUM_CH, 5'd0), 7'(i % NUM_CH),
                    48'h123456789ABC, 1'b0);
    end
    waitReady(2, "blk0_ready");
    for (int k = 0; k < 126; k++) begin
      applyStimulus(1'b0, 16'h0, 7'h0, 48'h0, 1'b1);
      if (k == 5) cap = BRAM_rd_data;
      checkOutput($sformatf("b0_w%0d", k), BRAM_rd_data,
                  expWord((k < 125) ? k : 124, 5'd0, 48'h123456789ABC));
      checkOutput($sformatf("b0_rdy%0d", k), {255'b0, BRAM_ready}, (k < 124) ? 256'd1 : 256'd0);
    end
    checkOutput("b0_word0", expWord(0, 5'd0, 48'h123456789ABC) ^ 256'h123456789ABC, 256'd0);
    checkOutput("b0_w5_lane3", {240'b0, cap[63:48]}, {240'b0, 4'd3, 7'd4, 5'd0});
    idle(1);
    checkOutput("b0_gap_ready", {255'b0, BRAM_ready}, 256'd0);

    // Overflow: three blocks with no reads, then ping-pong order
    sendBlock(5'd1, 48'h1000, BLK, -1);
    sendBlock(5'd2, 48'h2000, BLK, -1);
    checkOutput("ovf_before", {255'b0, overflow}, 256'd0);
    sendBlock(5'd3, 48'h3000, BLK, -1);
    checkOutput("ovf_set", {255'b0, overflow}, 256'd1);
    readBurst(5'd1, 48'h1000, "ovf_b1");
    sendBlock(5'd4, 48'h4000, BLK, -1);
    readBurst(5'd2, 48'h2000, "ovf_b2");
    readBurst(5'd4, 48'h4000, "ovf_b4");
    checkOutput("ovf_sticky", {255'b0, overflow}, 256'd1);

    // Continuous input while draining
    doReset();
    sidx = 0; w = 0; bursts = 0;
    for (int cyc = 0; cyc < 4 * BLK + 600 && bursts < 4; cyc++) begin
      if (sidx < 4 * BLK) begin
        blk = sidx / BLK;
        pos = sidx % BLK;
        in_valid     = 1'b1;
        in_data      = sampleVal(pos / NUM_CH, pos % NUM_CH, 5'(5 + blk));
        in_ch_id     = 7'(pos % NUM_CH);
        in_timestamp = 48'(32'h5000 + blk * 256);
        sidx++;
      end else begin
        in_valid = 1'b0;
      end
      pend            = BRAM_ready;
      BRAM_rd_request = pend;
      @(posedge clk);
      #1;
      if (pend) begin
        if (w == 0) begin
          checkOutput($sformatf("cont_ts%0d", bursts), BRAM_rd_data,
                      expWord(0, 5'd0, 48'(32'h5000 + bursts * 256)));
        end
        if (w == NUM_CH) begin
          checkOutput($sformatf("cont_last%0d", bursts), BRAM_rd_data,
                      expWord(NUM_CH, 5'(5 + bursts), 48'h0));
          bursts++;
        end
        w = (w == NUM_CH) ? 0 : w + 1;
      end
    end
    in_valid        = 1'b0;
    BRAM_rd_request = 1'b0;
    checkOutput("cont_bursts",   256'(bursts), 256'd4);
    checkOutput("cont_overflow", {255'b0, overflow}, 256'd0);

    // Channel id mismatch at t=3, ch=6
`ifdef ORDER_CHECK_EN
    sendBlock(5'd9, 48'h9000, 3 * NUM_CH + 7, 3 * NUM_CH + 6);
    checkOutput("ord_seq_err", {255'b0, seq_err}, 256'd1);
    idle(4);
    checkOutput("ord_no_ready", {255'b0, BRAM_ready}, 256'd0);
    sendBlock(5'd12, 48'hC000, BLK, -1);
    readBurst(5'd12, 48'hC000, "ord_clean");
`else
    sendBlock(5'd9, 48'h9000, BLK, 3 * NUM_CH + 6);
    checkOutput("ord_seq_err", {255'b0, seq_err}, 256'd0);
    readBurst(5'd9, 48'h9000, "ord_ignored");
`endif

    // Reset in the middle of a burst
    sendBlock(5'd10, 48'hA000, BLK, -1);
    waitReady(2, "mid_ready");
    for (int k = 0; k < 60; k++) applyStimulus(1'b0, 16'h0, 7'h0, 48'h0, 1'b1);
    checkOutput("mid_w59", BRAM_rd_data, expWord(59, 5'd10, 48'hA000));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_ready", {255'b0, BRAM_ready}, 256'd0);
    checkOutput("mid_rst_data",  BRAM_rd_data, 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    checkOutput("mid_after_ready", {255'b0, BRAM_ready}, 256'd0);
    sendBlock(5'd11, 48'hB000, BLK, -1);
    readBurst(5'd11, 48'hB000, "mid_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
